// File: rtl/kbonacci_pkg.sv
// kbonacci_pkg -- shared definitions for the k-bonacci sequence generator.
//   state_e           : FSM state encoding (IDLE, RUN, DONE)
//   MAX_ORDER         : largest supported ORDER (number of terms summed)
//   DEFAULT_SEED_TOP  : reset value of seed[ORDER-1]
//   DEFAULT_SEED_REST : reset value of every other seed
// Optional feature macro used by the slice: KBONACCI_GEN_SAT_EN (saturating terms).
package kbonacci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MAX_ORDER         = 8;
  localparam int DEFAULT_SEED_TOP  = 1;
  localparam int DEFAULT_SEED_REST = 0;

  // True for the seed slot that resets to DEFAULT_SEED_TOP.
  function automatic logic is_top_seed(input int idx, input int order);
    return idx == order - 1;
  endfunction

endpackage

// File: rtl/kbonacci_hist.sv
// kbonacci_hist -- ORDER-deep sliding window of terms plus the summing adder.
// The window holds t(n)..t(n+ORDER-1); win_q[0] is the term currently offered.
// Advancing shifts the window down and appends the sum of the whole window,
// which is t(n+ORDER). A per-slot flag remembers whether that term overflowed.
// Macro: KBONACCI_GEN_SAT_EN -- clamp overflowing terms to all-ones (else wrap).
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   load_i        : load window from seed_flat_i (seed k -> slot k)
//   adv_i         : shift window and append the new term
//   seed_flat_i   : ORDER seeds packed, seed k at [k*DATA_WIDTH +: DATA_WIDTH]
//   cur_data_o    : current term t(n) (a flop, so it is a registered output)
//   cur_ovf_o     : current term was produced by an overflowing sum
module kbonacci_hist #(
  parameter int DATA_WIDTH = 32,
  parameter int ORDER      = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          load_i,
  input  logic                          adv_i,
  input  logic [ORDER*DATA_WIDTH-1:0]   seed_flat_i,
  output logic [DATA_WIDTH-1:0]         cur_data_o,
  output logic                          cur_ovf_o
);

  // Extra bits so the full sum of ORDER terms never loses a carry.
  localparam int SUM_W = DATA_WIDTH + $clog2(ORDER);

  logic [DATA_WIDTH-1:0] win_q [ORDER];
  logic [ORDER-1:0]      wovf_q;
  logic [SUM_W-1:0]      sum;
  logic                  sum_ovf;
  logic [DATA_WIDTH-1:0] new_term;

  always_comb begin
    sum = '0;
    for (int k = 0; k < ORDER; k++) begin
      sum = sum + SUM_W'(win_q[k]);
    end
  end

  assign sum_ovf = |sum[SUM_W-1:DATA_WIDTH];

`ifdef KBONACCI_GEN_SAT_EN
  assign new_term = sum_ovf ? '1 : sum[DATA_WIDTH-1:0];
`else
  assign new_term = sum[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < ORDER; k++) begin
        win_q[k] <= '0;
      end
      wovf_q <= '0;
    end else if (load_i) begin
      for (int k = 0; k < ORDER; k++) begin
        win_q[k] <= seed_flat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      wovf_q <= '0;
    end else if (adv_i) begin
      for (int k = 0; k < ORDER - 1; k++) begin
        win_q[k] <= win_q[k+1];
      end
      win_q[ORDER-1] <= new_term;
      wovf_q         <= {sum_ovf, wovf_q[ORDER-1:1]};
    end
  end

  assign cur_data_o = win_q[0];
  assign cur_ovf_o  = wovf_q[0];

endmodule

// File: rtl/kbonacci_gen.sv
// kbonacci_gen -- emits t(0)..t(num_terms-1) of a k-bonacci sequence over a
// valid/ready stream. t(i)=seed[i] for i<ORDER, later terms sum the previous ORDER.
// Macro: KBONACCI_GEN_SAT_EN -- saturate overflowing terms (default build wraps).
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   start, num_terms     : begin a run of num_terms terms (IDLE only)
//   seed_we/idx/data     : seed register write (IDLE only; out-of-range idx ignored)
//   out_valid/ready/data : term stream; out_last marks the final term
//   busy                 : high while in RUN
//   done                 : one-cycle pulse when a run completes
//   ovf                  : sticky, set when an emitted term overflowed
module kbonacci_gen
  import kbonacci_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ORDER      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [CNT_WIDTH-1:0]     num_terms,
  input  logic                     seed_we,
  input  logic [$clog2(ORDER)-1:0] seed_idx,
  input  logic [DATA_WIDTH-1:0]    seed_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;   // terms still to be offered after the current one
  logic                    out_valid_q, out_last_q, busy_q, done_q, ovf_q;
  logic [DATA_WIDTH-1:0]   seed_q [ORDER];
  logic [ORDER*DATA_WIDTH-1:0] seed_flat;
  logic                    xfer, hist_load, hist_adv, cur_ovf;

  assign xfer      = out_valid_q && out_ready;
  assign hist_load = (state_q == ST_IDLE) && start && (num_terms != '0);
  // The last term's transfer leaves the window as-is; no term follows it.
  assign hist_adv  = (state_q == ST_RUN) && xfer && !out_last_q;

  // Seed registers: writable only in IDLE, survive runs, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < ORDER; k++) begin
        seed_q[k] <= is_top_seed(k, ORDER) ? DATA_WIDTH'(DEFAULT_SEED_TOP)
                                           : DATA_WIDTH'(DEFAULT_SEED_REST);
      end
    end else if ((state_q == ST_IDLE) && seed_we) begin
      for (int k = 0; k < ORDER; k++) begin
        if (32'(seed_idx) == k) seed_q[k] <= seed_data;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ORDER; gi++) begin : g_seed_flat
      assign seed_flat[gi*DATA_WIDTH +: DATA_WIDTH] = seed_q[gi];
    end
  endgenerate

  kbonacci_hist #(
    .DATA_WIDTH (DATA_WIDTH),
    .ORDER      (ORDER)
  ) u_hist (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (hist_load),
    .adv_i       (hist_adv),
    .seed_flat_i (seed_flat),
    .cur_data_o  (out_data),
    .cur_ovf_o   (cur_ovf)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ovf_q <= 1'b0;
            if (num_terms != '0) begin
              state_q     <= ST_RUN;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b1;
              out_last_q  <= (num_terms == CNT_WIDTH'(1));
              cnt_q       <= num_terms - CNT_WIDTH'(1);
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Flag lands one cycle after the offending term appears; still before DONE.
          if (cur_ovf) ovf_q <= 1'b1;
          if (xfer) begin
            if (out_last_q) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              cnt_q       <= '0;
            end else begin
              cnt_q      <= cnt_q - CNT_WIDTH'(1);
              out_last_q <= (cnt_q == CNT_WIDTH'(1));
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_kbonacci_gen.sv
// tb_kbonacci_gen -- self-checking bench. Two instances share all inputs:
//   A: DATA_WIDTH=8,  ORDER=2 (Fibonacci, small width for overflow)
//   B: DATA_WIDTH=16, ORDER=3 (default seeds 0,0,1)
// Expected terms come from a direct evaluation of the recurrence.
// Honours KBONACCI_GEN_SAT_EN for expected overflow behaviour.
module tb_kbonacci_gen;

  localparam int CW = 16;

`ifdef KBONACCI_GEN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [CW-1:0] num_terms;
  logic          seed_we;
  logic [1:0]    seed_idx;
  logic [15:0]   seed_data;
  logic          out_ready;
  logic          seed_we_a;

  logic       valid_a, last_a, busy_a, done_a, ovf_a;
  logic [7:0] data_a;
  logic       valid_b, last_b, busy_b, done_b, ovf_b;
  logic [15:0] data_b;

  // Instance A only has seed slots 0..1; keep slot-2 writes away from it.
  assign seed_we_a = seed_we && (seed_idx < 2'd2);

  kbonacci_gen #(.DATA_WIDTH(8), .ORDER(2), .CNT_WIDTH(CW)) u_dut_a (
    .clk(clk), .resetn(resetn), .start(start), .num_terms(num_terms),
    .seed_we(seed_we_a), .seed_idx(seed_idx[0]), .seed_data(seed_data[7:0]),
    .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a),
    .out_last(last_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  kbonacci_gen #(.DATA_WIDTH(16), .ORDER(3), .CNT_WIDTH(CW)) u_dut_b (
    .clk(clk), .resetn(resetn), .start(start), .num_terms(num_terms),
    .seed_we(seed_we), .seed_idx(seed_idx), .seed_data(seed_data),
    .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b),
    .out_last(last_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int     cmp_cnt = 0;
  int     err_cnt = 0;
  longint seeds [2][3];
  longint exp_t [2][64];
  bit     exp_ovf [2];
  longint last_term_a;

  typedef struct {
    int     n;
    int     mode;      // 0: ready high, 1: ready toggles, 2: random ready
    longint exp_last;  // final term of instance A with default seeds
    bit     exp_ovf;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input longint act, input longint exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_model();
    seeds[0] = '{0, 1, 0};
    seeds[1] = '{0, 0, 1};
  endtask

  // Evaluate the recurrence for both instances from their current seeds.
  task automatic build_model(input int n);
    for (int d = 0; d < 2; d++) begin
      int     ord;
      longint lim;
      longint v;
      ord = (d == 0) ? 2 : 3;
      lim = (d == 0) ? 256 : 65536;
      exp_ovf[d] = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (i < ord) begin
          v = seeds[d][i];
        end else begin
          v = 0;
          for (int k = 1; k <= ord; k++) v += exp_t[d][i-k];
          if (v >= lim) begin
            exp_ovf[d] = 1'b1;
            v = SAT ? lim - 1 : v % lim;
          end
        end
        exp_t[d][i] = v;
      end
    end
  endtask

  task automatic write_seed(input int idx, input int data);
    @(negedge clk);
    seed_we   = 1'b1;
    seed_idx  = 2'(idx);
    seed_data = 16'(data);
    @(negedge clk);
    seed_we = 1'b0;
    if (idx < 2) seeds[0][idx] = longint'(data) & 255;
    if (idx < 3) seeds[1][idx] = longint'(data) & 65535;
  endtask

  // One start/stream/done transaction; poke drives start and seed_we mid-run.
  task automatic run_seq(input int n, input int mode, input bit poke);
    int     idx;
    int     cycles;
    bit     stalled;
    bit     poked;
    longint hold_a, hold_b, hold_la;
    build_model(n);
    @(negedge clk);
    start     = 1'b1;
    num_terms = CW'(n);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done_a", done_a, 1);
      chk("zero_done_b", done_b, 1);
      chk("zero_valid_a", valid_a, 0);
      chk("zero_valid_b", valid_b, 0);
      @(negedge clk);
      chk("zero_done_clr_a", done_a, 0);
      chk("zero_valid2_a", valid_a, 0);
      chk("zero_ovf_a", ovf_a, 0);
      chk("zero_ovf_b", ovf_b, 0);
      $display("run n=0 mode=%0d done-only ovf_a=%0b ovf_b=%0b", mode, ovf_a, ovf_b);
      return;
    end
    chk("busy_a", busy_a, 1);
    chk("busy_b", busy_b, 1);
    idx = 0; cycles = 0; stalled = 1'b0; poked = 1'b0;
    hold_a = 0; hold_b = 0; hold_la = 0;
    while (idx < n && cycles < 4*n + 20) begin
      start   = 1'b0;
      seed_we = 1'b0;
      chk("valid_a", valid_a, 1);
      chk("valid_b", valid_b, 1);
      if (stalled) begin
        chk("stable_a", data_a, hold_a);
        chk("stable_b", data_b, hold_b);
        chk("stable_last_a", last_a, hold_la);
      end
      if (poke && !poked && idx == 2) begin
        start     = 1'b1;
        num_terms = CW'(3);
        seed_we   = 1'b1;
        seed_idx  = 2'd0;
        seed_data = 16'd99;
        poked     = 1'b1;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cycles[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_ready) begin
        chk("data_a", data_a, exp_t[0][idx]);
        chk("data_b", data_b, exp_t[1][idx]);
        chk("last_a", last_a, longint'(idx == n - 1));
        chk("last_b", last_b, longint'(idx == n - 1));
        if (idx == n - 1) last_term_a = data_a;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hold_a  = data_a;
        hold_b  = data_b;
        hold_la = last_a;
      end
      @(negedge clk);
      cycles++;
    end
    start   = 1'b0;
    seed_we = 1'b0;
    if (idx < n) begin
      chk("timeout_terms", idx, n);
    end else begin
      chk("done_a", done_a, 1);
      chk("done_b", done_b, 1);
      chk("end_valid_a", valid_a, 0);
      chk("end_valid_b", valid_b, 0);
      chk("end_busy_a", busy_a, 0);
      @(negedge clk);
      chk("done_clr_a", done_a, 0);
      chk("done_clr_b", done_b, 0);
      chk("ovf_a", ovf_a, exp_ovf[0]);
      chk("ovf_b", ovf_b, exp_ovf[1]);
    end
    out_ready = 1'b0;
    $display("run n=%0d mode=%0d poke=%0b last_a=%0d ovf_a=%0b ovf_b=%0b",
             n, mode, poke, last_term_a, ovf_a, ovf_b);
  endtask

  initial begin
    tbl[0] = '{n: 10, mode: 0, exp_last: 34,  exp_ovf: 1'b0};
    tbl[1] = '{n: 10, mode: 1, exp_last: 34,  exp_ovf: 1'b0};
    tbl[2] = '{n: 1,  mode: 0, exp_last: 0,   exp_ovf: 1'b0};
    tbl[3] = '{n: 14, mode: 2, exp_last: 233, exp_ovf: 1'b0};
    tbl[4] = '{n: 15, mode: 0, exp_last: SAT ? 255 : 121, exp_ovf: 1'b1};
    tbl[5] = '{n: 0,  mode: 0, exp_last: 0,   exp_ovf: 1'b0};
    tbl[6] = '{n: 2,  mode: 1, exp_last: 1,   exp_ovf: 1'b0};

    resetn = 1'b0; start = 1'b0; num_terms = '0; seed_we = 1'b0;
    seed_idx = '0; seed_data = '0; out_ready = 1'b0; last_term_a = 0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_valid_b", valid_b, 0);
    chk("rst_last_b", last_b, 0);
    resetn = 1'b1;

    // Default-seed table: A is Fibonacci mod 256, B is 0,0,1,1,2,4,7,...
    for (int i = 0; i < 7; i++) begin
      last_term_a = -1;
      run_seq(tbl[i].n, tbl[i].mode, 1'b0);
      if (tbl[i].n != 0) chk("tbl_last_a", last_term_a, tbl[i].exp_last);
      chk("tbl_ovf_a", ovf_a, tbl[i].exp_ovf);
    end

    // start and seed writes during RUN must be ignored.
    run_seq(8, 0, 1'b1);
    run_seq(7, 1, 1'b0);

    // Custom seeds, then reset after three transfers.
    write_seed(0, 5);
    write_seed(1, 7);
    write_seed(2, 3);
    build_model(10);
    @(negedge clk);
    start = 1'b1; num_terms = CW'(10);
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_data_a", data_a, exp_t[0][3]);
    chk("pre_rst_data_b", data_b, exp_t[1][3]);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid_a", valid_a, 0);
    chk("mid_rst_valid_b", valid_b, 0);
    chk("mid_rst_busy_a", busy_a, 0);
    chk("mid_rst_data_a", data_a, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_no_done_a", done_a, 0);
      chk("mid_rst_no_done_b", done_b, 0);
    end
    resetn = 1'b1; out_ready = 1'b0;
    $display("reset mid-run after 3 transfers");
    reset_model();
    run_seq(10, 0, 1'b0);
    chk("post_rst_last_a", last_term_a, 34);

    // Random seeds, lengths and back-pressure.
    for (int r = 0; r < 25; r++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        write_seed($urandom_range(0, 2), $urandom_range(0, 65535));
      end
      run_seq($urandom_range(0, 20), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/kbonacci_gen.md
KBONACCI_GEN -- requirements
Module: kbonacci_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, term width in bits.
REQ-002 The block SHALL have parameter ORDER, default 2, number of prior terms summed (legal 2..8).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, width of the term-count field.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-005 The block SHALL have port resetn, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, request a new sequence.
REQ-007 The block SHALL have port num_terms, input, CNT_WIDTH, terms to emit; sampled when start is accepted.
REQ-008 The block SHALL have port seed_we, input, 1, seed write strobe.
REQ-009 The block SHALL have port seed_idx, input, $clog2(ORDER), seed register index.
REQ-010 The block SHALL have port seed_data, input, DATA_WIDTH, seed write value.
REQ-011 The block SHALL have port out_valid, output, 1, out_data holds a valid term.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts the term.
REQ-013 The block SHALL have port out_data, output, DATA_WIDTH, current term.
REQ-014 The block SHALL have port out_last, output, 1, current term is the final term of the run.
REQ-015 The block SHALL have port busy, output, 1, high in RUN.
REQ-016 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-017 The block SHALL have port ovf, output, 1, sticky overflow flag.

Function
REQ-018 The sequence SHALL be t(i)=seed[i] for i<ORDER and t(n)=t(n-1)+...+t(n-ORDER) for n>=ORDER; terms t(0)..t(num_terms-1) SHALL be emitted in order.
REQ-019 The FSM SHALL have states IDLE, RUN and DONE, encoded as an enum.
REQ-020 IDLE: start with num_terms!=0 SHALL go to RUN, load the history from the seeds, latch the count and clear ovf; start with num_terms==0 SHALL go to DONE with no valid term.
REQ-021 out_valid SHALL assert the cycle after start is accepted; sustained throughput SHALL be one term per cycle while out_ready=1.
REQ-022 A transfer occurs when out_valid and out_ready are both high; out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 out_last SHALL be high exactly on the term with index num_terms-1; its transfer SHALL move the FSM to DONE and drop out_valid.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-025 start SHALL be ignored outside IDLE, and seed_we SHALL be ignored outside IDLE.
REQ-026 The sum SHALL be computed at DATA_WIDTH+$clog2(ORDER) bits; any term reaching 2^DATA_WIDTH or above SHALL set ovf, which stays set until the next accepted start.
REQ-027 Without the saturation feature, terms SHALL wrap modulo 2^DATA_WIDTH and the wrapped value SHALL enter the history.

Reset
REQ-028 On resetn low, all flops SHALL clear asynchronously: state=IDLE; out_valid, out_last, busy, done and ovf =0; out_data=0; count=0.
REQ-029 On reset, seeds SHALL reset to seed[ORDER-1]=1 and all other seeds=0, so the default ORDER=2 sequence is Fibonacci 0,1,1,2...
REQ-030 Reset mid-run SHALL abort the run immediately with no done pulse; seeds SHALL persist across runs except on reset.

Configuration
REQ-031 Macro KBONACCI_GEN_SAT_EN, when defined, SHALL clamp any overflowing term to all-ones and keep the clamped value in the history; ovf SHALL still be set.
REQ-032 Without KBONACCI_GEN_SAT_EN, the block SHALL wrap as in REQ-027 and contain no saturation logic.

Structure
REQ-033 Package kbonacci_pkg SHALL hold the state enum typedef, MAX_ORDER=8 and the default-seed constants.
REQ-034 The ORDER-deep history shift register and adder tree SHALL be a sub-module kbonacci_hist; the top SHALL hold the FSM, counter, seeds and handshake.

Verification
REQ-035 ORDER=2, default seeds, num_terms=10, ready=1 -> 0,1,1,2,3,5,8,13,21,34; out_last on 34; done one cycle after.
REQ-036 ORDER=3, seeds {0,0,1}, num_terms=7 -> 0,0,1,1,2,4,7; ovf=0.
REQ-037 Case REQ-035 with out_ready toggling each cycle -> same sequence; out_data stable during every stall.
REQ-038 DATA_WIDTH=8, ORDER=2, num_terms=15 -> t13=233, t14=121 with ovf=1 (wrap); with KBONACCI_GEN_SAT_EN t14=255.
REQ-039 num_terms=0 with start -> done pulse, out_valid never asserts; start during RUN -> ignored.
REQ-040 resetn low after 3 transfers -> out_valid=0 immediately, no done; a later start restarts from the default seeds at 0.
